// File: rtl/regfile_dump_reader_if.sv
// Output stream bundle for regfile_dump_reader: one register entry per handshake.
// master drives valid/data/index/last and samples ready; slave is the consumer.
interface regfile_dump_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks registers 0..NUM_REGS-1 through one read port and
// streams each sampled value on bus (valid/ready). Ports: clk, rst_n (async
// active-low), start/abort requests, rf_addr/rf_data read port, bus master
// stream, busy (not IDLE) and done (one-cycle pulse after the last entry).
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    regfile_dump_reader_if.master bus,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_index;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic                  r_done;

    // The counter is cleared whenever IDLE is entered, so it doubles as the
    // read address and holds 0 while idle.
    assign rf_addr       = r_cnt;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_index = r_index;
    assign bus.out_last  = r_last;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && abort) begin
                // Cancel wins over any handshake; last entry fields are kept.
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_state <= S_READ;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_READ: begin
                        r_data  <= rf_data;
                        r_index <= r_cnt;
                        r_last  <= (r_cnt == LAST_IDX);
                        r_valid <= 1'b1;
                        r_state <= S_SEND;
                    end
                    S_SEND: begin
                        if (bus.out_ready) begin
                            r_valid <= 1'b0;
                            if (r_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_cnt   <= r_cnt + 1'b1;
                                r_state <= S_READ;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a 16x16 register file model.
// Covers full dump, backpressure, writes mid-dump, abort, ignored start, async reset.
module tb_regfile_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  rf_addr;
    logic [15:0] rf_data;
    logic        busy;
    logic        done;
    logic [15:0] rf [16];
    logic [15:0] exp_d [16];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ncyc;

    regfile_dump_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_if ();

    regfile_dump_reader #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(4),
        .NUM_REGS(16)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .rf_addr(rf_addr),
        .rf_data(rf_data),
        .bus    (u_if.master),
        .busy   (busy),
        .done   (done)
    );

    assign rf_data = rf[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (u_if.out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("valid_wait", {31'd0, u_if.out_valid}, 32'd1);
    endtask

    task automatic rf_init();
        for (int i = 0; i < 16; i++) begin
            rf[i]    = 16'h1000 + 16'(i);
            exp_d[i] = 16'h1000 + 16'(i);
        end
    endtask

    // One dump; -1 disables an action. Returns edges from start-accept to done.
    task automatic dump(input int abort_at, input int bp_at, input int wr_at,
                        input int st_at, output int cycles);
        int c0;
        cycles = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            wait_valid(4);
            chk("index", {28'd0, u_if.out_index}, 32'(k));
            chk("data", {16'd0, u_if.out_data}, {16'd0, exp_d[k]});
            chk("last", {31'd0, u_if.out_last}, {31'd0, (k == 15)});
            if (k == wr_at) begin
                rf[10]    = 16'hBEEF;
                rf[2]     = 16'hDEAD;
                exp_d[10] = 16'hBEEF;
            end
            if (k == st_at)
                start = 1'b1;
            if (k == bp_at) begin
                u_if.out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    step();
                    chk("bp_valid", {31'd0, u_if.out_valid}, 32'd1);
                    chk("bp_data", {16'd0, u_if.out_data}, {16'd0, exp_d[k]});
                    chk("bp_index", {28'd0, u_if.out_index}, 32'(k));
                end
                u_if.out_ready = 1'b1;
            end
            if (k == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk("abort_valid", {31'd0, u_if.out_valid}, 32'd0);
                chk("abort_last", {31'd0, u_if.out_last}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_index", {28'd0, u_if.out_index}, 32'(k));
                chk("abort_data", {16'd0, u_if.out_data}, {16'd0, exp_d[k]});
                for (int j = 0; j < 4; j++) begin
                    step();
                    chk("abort_quiet", {30'd0, u_if.out_valid, done}, 32'd0);
                end
                return;
            end
            step();
            start = 1'b0;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd1);
        cycles = cyc - c0;
        step();
        chk("done_clear", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, u_if.out_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        u_if.out_ready = 1'b1;
        rf_init();
        #1;
        chk("rst_valid", {31'd0, u_if.out_valid}, 32'd0);
        chk("rst_data", {16'd0, u_if.out_data}, 32'd0);
        chk("rst_index", {28'd0, u_if.out_index}, 32'd0);
        chk("rst_flags", {29'd0, u_if.out_last, busy, done}, 32'd0);
        chk("rst_addr", {28'd0, rf_addr}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full dump with ready high; the start cycle plus 32 edges = 33 cycles.
        dump(-1, -1, -1, -1, ncyc);
        chk("dump_cycles", 32'(ncyc), 32'd32);

        // Backpressure on index 3, writes while index 4 pending, start at 5.
        rf_init();
        dump(-1, 3, 4, 5, ncyc);
        chk("bp_cycles", 32'(ncyc), 32'd37);
        rf_init();

        // Abort with ready high on index 7, then restart from index 0.
        dump(7, -1, -1, -1, ncyc);
        dump(-1, -1, -1, -1, ncyc);
        chk("restart_cycles", 32'(ncyc), 32'd32);

        // start together with abort in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("sa_idle", {30'd0, busy, u_if.out_valid}, 32'd0);
        end

        // Asynchronous reset between edges during index 2.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid(4);
            if (k < 2)
                step();
        end
        chk("pre_rst_index", {28'd0, u_if.out_index}, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, u_if.out_valid}, 32'd0);
        chk("arst_data", {16'd0, u_if.out_data}, 32'd0);
        chk("arst_index", {28'd0, u_if.out_index}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_addr", {28'd0, rf_addr}, 32'd0);
        #2;
        rst_n = 1'b1;
        dump(-1, -1, -1, -1, ncyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the 16x16 register file: on request, walks every register through one read port and streams each value out over a valid/ready handshake.
- Sits beside the datapath as a debug and observation port. It drives the register file's read address and samples the combinational read data.
- It never writes the register file.

Parameters:
- DATA_WIDTH, 16, width of one register value.
- ADDR_WIDTH, 4, width of the register address.
- NUM_REGS, 16, number of registers walked, indices 0..NUM_REGS-1; must be <= 2**ADDR_WIDTH and >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel of a dump in progress.
- rf_addr  output  ADDR_WIDTH  read address driven to a register file read port.
- rf_data  input  DATA_WIDTH  combinational read data returned for rf_addr.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the current entry.
- out_data  output  DATA_WIDTH  captured register value.
- out_index  output  ADDR_WIDTH  register number of out_data.
- out_last  output  1  high with the entry for index NUM_REGS-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last entry is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; rf_addr, out_data, out_index = 0; out_valid, out_last, busy, done = 0.
- All other state changes occur on the rising edge of clk.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - rf_addr held at 0.
  - start=1 -> READ, with the address counter at 0.
- READ (one cycle):
  - rf_addr = counter.
  - At the clock edge: out_data <= rf_data; out_index <= counter; out_last <= (counter==NUM_REGS-1); out_valid <= 1.
  - Next state is SEND.
- SEND:
  - out_valid=1. out_data, out_index and out_last stay stable until the handshake (out_valid && out_ready).
  - On handshake with out_last=0: out_valid <= 0, counter+1, -> READ.
  - On handshake with out_last=1: out_valid <= 0, -> DONE.
- DONE (one cycle): done=1, busy=1 -> IDLE. done is 0 in every other state.
- Latency:
  - start accepted at edge N -> out_valid high from edge N+1.
  - With out_ready tied high, one entry is accepted every 2 cycles.
  - A full 16-entry dump takes 33 cycles from start to the done pulse.
- Snapshot semantics:
  - Each value is sampled in its own READ cycle.
  - A register file write landing before that READ edge is reflected; one landing after it is not.
  - There is no whole-file atomic snapshot.
- start while busy: ignored, no restart and no queuing.
- abort: in any non-IDLE state, abort has priority over a handshake in the same cycle.
  - Next state is IDLE with out_valid=0 and out_last=0.
  - No done pulse is produced. out_data and out_index keep their last values.
- start and abort asserted together in IDLE: abort wins and the block stays IDLE.
- Counter:
  - Width ADDR_WIDTH. It never passes NUM_REGS-1, so no wrap occurs.
  - With NUM_REGS=1 the block emits a single entry with out_last=1.
- Reset mid-dump: immediate return to the reset values; the next start begins again at index 0.

Test Plan:
- Register file preloaded with reg[i]=16'h1000+i, out_ready=1, start pulse -> 16 entries, index 0..15, data 16'h1000..16'h100F. out_last only on index 15. done pulse 33 cycles after start. busy low afterwards.
- Backpressure: out_ready held low for 5 cycles on index 3 -> out_valid, out_data=16'h1003 and out_index=3 stay stable for all 5 cycles. Index 4 is emitted only after out_ready rises. No entry lost or duplicated.
- Write during dump: reg[10] written 16'hBEEF while index 4 is pending, reg[2] written 16'hDEAD at the same time -> index 10 reports 16'hBEEF, index 2 keeps its earlier value.
- abort asserted in the SEND cycle of index 7 with out_ready=1 -> no handshake for index 7 is counted. out_valid drops next cycle, no done pulse, busy=0. A new start then streams again from index 0.
- start pulsed during a dump and together with abort in IDLE -> no restart and no extra entries; the dump started with abort remains idle.
- rst_n low asynchronously mid-dump (between edges) -> outputs go to 0 immediately without waiting for clk. After rst_n returns high, a start yields index 0 first.
